// File: rtl/modulo_magazine_rolhas.sv
// Principal cork magazine: holds the cork count, pulls refills from the
// secondary buffer at the minimum level and serves one cork per sealing request.
//
// Ports:
//   clk              - rising-edge system clock
//   clr              - synchronous active-low reset
//   enable           - machine running; 0 stops refills, not consumption
//   ved_req          - one-cycle request for a cork from the sealing FSM
//   ved_ack          - registered pulse, cork served
//   ved_falha        - registered pulse, request hit an empty magazine
//   sec_vazio        - secondary buffer empty
//   trf_req          - refill in progress (REABASTECE or ESPERA)
//   trf_valid        - secondary offers a cork this cycle
//   trf_ready        - magazine accepts a cork this cycle
//   nivel            - current cork count
//   ro               - magazine empty
//   min_signal       - count at or below refill threshold
//   cheio            - magazine full
//   total_consumidas - corks served since reset, saturating at 99
module modulo_magazine_rolhas #(
    parameter int LARGURA    = 5,
    parameter int CAPACIDADE = 20,
    parameter int MINIMO     = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enable,
    input  logic               ved_req,
    output logic               ved_ack,
    output logic               ved_falha,
    input  logic               sec_vazio,
    output logic               trf_req,
    input  logic               trf_valid,
    output logic               trf_ready,
    output logic [LARGURA-1:0] nivel,
    output logic               ro,
    output logic               min_signal,
    output logic               cheio,
    output logic [6:0]         total_consumidas
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        REABASTECE = 2'b01,
        ESPERA     = 2'b10,
        ILEGAL     = 2'b11
    } estado_t;

    localparam logic [LARGURA-1:0] CAP = LARGURA'(CAPACIDADE);
    localparam logic [LARGURA-1:0] MIN = LARGURA'(MINIMO);
    localparam logic [LARGURA-1:0] UM  = LARGURA'(1);

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] nivel_q, nivel_d;
    logic [6:0]         total_q, total_d;
    logic               ack_q, falha_q;

    logic beat;
    logic cons;
    logic falha;

    assign ro         = (nivel_q == '0);
    assign min_signal = (nivel_q <= MIN);
    assign cheio      = (nivel_q == CAP);

    // Moore ready: never looks at trf_valid, so no combinational loop
    // through the secondary side.
    assign trf_ready = (estado_q == REABASTECE) && !cheio;
    assign trf_req   = (estado_q == REABASTECE) || (estado_q == ESPERA);

    assign beat  = trf_valid && trf_ready;
    assign cons  = ved_req && !ro;
    assign falha = ved_req && ro;

    always_comb begin
        nivel_d = nivel_q;
        unique case ({beat, cons})
            2'b10:   nivel_d = nivel_q + UM;
            2'b01:   nivel_d = nivel_q - UM;
            default: nivel_d = nivel_q;
        endcase
    end

    always_comb begin
        total_d = total_q;
        if (cons && (total_q != 7'd99)) begin
            total_d = total_q + 7'd1;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (enable && min_signal) begin
                    estado_d = sec_vazio ? ESPERA : REABASTECE;
                end
            end
            REABASTECE: begin
                // Full only counts when a beat actually lands the last cork;
                // a beat cancelled by a same-cycle consumption does not.
                if (!enable) begin
                    estado_d = OCIOSO;
                end else if (beat && (nivel_d == CAP)) begin
                    estado_d = OCIOSO;
                end else if (sec_vazio) begin
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (!enable) begin
                    estado_d = OCIOSO;
                end else if (!sec_vazio) begin
                    estado_d = REABASTECE;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            estado_q <= OCIOSO;
            nivel_q  <= '0;
            total_q  <= '0;
            ack_q    <= 1'b0;
            falha_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            nivel_q  <= nivel_d;
            total_q  <= total_d;
            ack_q    <= cons;
            falha_q  <= falha;
        end
    end

    assign nivel            = nivel_q;
    assign total_consumidas = total_q;
    assign ved_ack          = ack_q;
    assign ved_falha        = falha_q;

endmodule

// File: doc/modulo_magazine_rolhas.md
# modulo_magazine_rolhas

Principal cork magazine controller: the receiving end of the secondary-to-principal cork transfer. It holds the principal cork count, requests refills from the secondary buffer when the count falls to the minimum, and accepts one cork per handshake beat until full. It serves one cork per sealing request from the filling/sealing FSM and reports the out-of-corks (`ro`) and minimum-level flags back to that FSM and the display path.

## Interface
- `LARGURA`, default 5: width of the magazine count.
- `CAPACIDADE`, default 20: maximum corks held; must be < 2^LARGURA.
- `MINIMO`, default 5: refill threshold; the magazine requests a refill when the count is ≤ MINIMO.

- `clk`, in, 1: single system clock (the divided clock); all logic on the rising edge.
- `clr`, in, 1: reset, synchronous, active-low.
- `enable`, in, 1: machine running (start/stop); 0 blocks refills but not consumption.
- `ved_req`, in, 1: one-cycle pulse from the sealing FSM requesting one cork.
- `ved_ack`, out, 1: registered one-cycle pulse; the cork was served.
- `ved_falha`, out, 1: registered one-cycle pulse; the request arrived with the magazine empty.
- `sec_vazio`, in, 1: secondary buffer is empty.
- `trf_req`, out, 1: refill in progress; high in REABASTECE and ESPERA.
- `trf_valid`, in, 1: the secondary side offers one cork this cycle.
- `trf_ready`, out, 1: the magazine accepts a cork this cycle.
- `nivel`, out, LARGURA: current principal cork count.
- `ro`, out, 1: `nivel == 0`.
- `min_signal`, out, 1: `nivel <= MINIMO`.
- `cheio`, out, 1: `nivel == CAPACIDADE`.
- `total_consumidas`, out, 7: corks served since reset; saturates at 99.

## Operation
- **States:**
  - OCIOSO (00)
  - REABASTECE (01)
  - ESPERA (10)
  - 11 is illegal and returns to OCIOSO next cycle.
- **Transitions:**
  - OCIOSO → REABASTECE when `enable && min_signal && !sec_vazio`.
  - OCIOSO → ESPERA when `enable && min_signal && sec_vazio`.
  - REABASTECE → OCIOSO when `!enable`, or when an accepted cork makes `nivel` reach CAPACIDADE.
  - REABASTECE → ESPERA when `sec_vazio && enable`.
  - ESPERA → REABASTECE when `!sec_vazio && enable`.
  - ESPERA → OCIOSO when `!enable`.
- **Handshakes:**
  - `trf_ready` = (state == REABASTECE) && !cheio. It is Moore, i.e. it does not depend on `trf_valid`.
  - A transfer beat is `trf_valid && trf_ready`; the magazine adds +1 to `nivel` at that edge.
  - Consumption happens on `ved_req` with `nivel > 0` (sampled before this cycle's update): −1 to `nivel`, then `ved_ack` is high the next cycle, and `total_consumidas` +1 unless already 99.
  - `ved_req` with `nivel == 0` → `ved_falha` the next cycle, `nivel` unchanged. This applies even if a transfer beat occurs in the same cycle.
  - Consumption works in every state and regardless of `enable`.
- **Arithmetic:**
  - Beat and consumption in the same cycle: net 0. `nivel` is unchanged and `ved_ack` still pulses.
  - `nivel` never exceeds CAPACIDADE: no beat is possible when `cheio`.
  - `nivel` never underflows below 0.
- **Flags:** `ro`, `min_signal` and `cheio` are combinational from registered `nivel`.

## Timing
- **Reset** (`clr` = 0 at a rising edge), which takes priority over all other inputs, including mid-refill:
  - `nivel` = 0, state OCIOSO, `total_consumidas` = 0.
  - `ved_ack`, `ved_falha`, `trf_req`, `trf_ready` = 0.
  - `ro` = 1, `min_signal` = 1, `cheio` = 0.
  - A beat offered in the same cycle as reset is lost.
- **Latencies:**
  - Refill start: `trf_req`/`trf_ready` rise 1 cycle after the edge where `nivel` first satisfies `min_signal` with `enable` = 1 and `sec_vazio` = 0.
  - Sustained throughput is 1 cork per cycle while `trf_valid` is held high.
  - `ved_ack`/`ved_falha` arrive exactly 1 cycle after `ved_req` and are never high together.
- **Full:** the beat that makes `nivel` = CAPACIDADE is the last one; `trf_ready` = 0 on the following cycle.
- **`enable` falling mid-refill:** state goes to OCIOSO at the next edge. A beat in that same cycle is still accepted, because `trf_ready` was already high.

## Test plan
- **Reset and first refill:** release `clr`, set `enable` = 1, `sec_vazio` = 0 → `ro` = 1 and `min_signal` = 1 at reset; `trf_ready` high 1 cycle later. Hold `trf_valid` high for 20 cycles → `nivel` = 20, `cheio` = 1, state OCIOSO, `trf_ready` low.
- **Consumption to empty:** from `nivel` = 20, issue 21 `ved_req` pulses with `enable` = 0 → 20 `ved_ack`, then 1 `ved_falha`; `nivel` = 0, `total_consumidas` = 20.
- **Threshold and simultaneous events:**
  - Consume from 6 to 5 with `enable` = 1 → `trf_req` rises the next cycle.
  - Assert `ved_req` and a transfer beat in the same cycle at `nivel` = 5 → `nivel` stays 5, `ved_ack` pulses.
- **Secondary empties mid-refill:** at `nivel` = 8 in REABASTECE, assert `sec_vazio` → ESPERA, `trf_ready` = 0 and `trf_req` = 1. Deassert → REABASTECE; refill completes to 20.
- **Reset mid-refill:** `clr` = 0 at `nivel` = 12 with `trf_valid` = 1 → next cycle `nivel` = 0, OCIOSO, all handshake outputs 0.
- **Saturation:** serve 105 corks across repeated refills → `total_consumidas` stops at 99.
